// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline stage registers: FSM state encodings,
// control/data bundle layout for the default RISC pipeline, and small helpers.
package pipe_pkg;

    // Stage occupancy state. EMPTY = nothing held, MAIN = one beat on the
    // outputs, FULL = one beat on the outputs plus one parked in the skid entry.
    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_MAIN  = 2'd1;
    localparam state_t ST_FULL  = 2'd2;

    // Field widths used by the stage bundles.
    localparam int ALUOP_W   = 2;
    localparam int REGADDR_W = 5;
    localparam int XLEN      = 32;

    // Control bundle layout (default 10-bit bundle). Every field is active-high,
    // so an all-zero bundle is a NOP for the downstream stage.
    localparam int CTRL_REGWRITE_OFS = 0;
    localparam int CTRL_MEMWRITE_OFS = 1;
    localparam int CTRL_MEMREAD_OFS  = 2;
    localparam int CTRL_MEMTOREG_OFS = 3;
    localparam int CTRL_ALUSRC_OFS   = 4;
    localparam int CTRL_BRANCH_OFS   = 5;
    localparam int CTRL_ALUOP_OFS    = 6;
    localparam int CTRL_JUMP_OFS     = CTRL_ALUOP_OFS + ALUOP_W;
    localparam int CTRL_RSVD_OFS     = CTRL_JUMP_OFS + 1;
    localparam int CTRL_DEFAULT_W    = CTRL_RSVD_OFS + 1;

    // Data bundle layout (default 138-bit bundle):
    // PC+4, read data 1, read data 2, immediate, rt, rd.
    localparam int DATA_PC4_OFS    = 0;
    localparam int DATA_RDATA1_OFS = DATA_PC4_OFS + XLEN;
    localparam int DATA_RDATA2_OFS = DATA_RDATA1_OFS + XLEN;
    localparam int DATA_IMM_OFS    = DATA_RDATA2_OFS + XLEN;
    localparam int DATA_RT_OFS     = DATA_IMM_OFS + XLEN;
    localparam int DATA_RD_OFS     = DATA_RT_OFS + REGADDR_W;
    localparam int DATA_DEFAULT_W  = DATA_RD_OFS + REGADDR_W;

    // A stage presents a valid beat in every state except EMPTY.
    function automatic logic is_occupied(input state_t s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Beat interface between two pipeline stages.
//
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both high. valid must not depend combinationally on ready. Once a sender
// raises valid it may change ctrl/data only after the transfer; this stage
// itself always holds ctrl/data stable while valid is high and ready is low.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_DEFAULT_W,
    parameter int DATA_W = DATA_DEFAULT_W
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    // Sender side of a stage boundary.
    modport master (
        output valid,
        output ctrl,
        output data,
        input  ready
    );

    // Receiver side of a stage boundary.
    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stage_reg_entry.sv
// One storage entry of a pipeline stage: a control bundle and a data bundle
// with independent clears, so a bubble can zero control while data is kept.
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_DEFAULT_W,
    parameter int DATA_W = DATA_DEFAULT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear_ctrl,
    input  logic              i_clear_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Control register: reset wins, then load, then clear to NOP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
        end else if (i_clear_ctrl) begin
            r_ctrl <= '0;
        end
    end

    // Data register: same priority, with its own clear so data may be kept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_clear_data) begin
            r_data <= '0;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// skid entry (registered ready), flush, bubble insertion and a saturating
// stall counter. Used at every stage boundary of the pipeline.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W      = CTRL_DEFAULT_W,
    parameter int DATA_W      = DATA_DEFAULT_W,
    parameter int SKID        = 1,
    parameter int CLEAR_DATA  = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    pipe_stage_reg_if.slave        i_up,
    pipe_stage_reg_if.master       o_dn,
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
    output state_t                 o_dbg_state
);

    localparam logic CLR_DATA_EN = (CLEAR_DATA != 0);
    localparam logic SKID_EN     = (SKID != 0);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ready;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_valid;
    logic w_ready;
    logic w_acc;
    logic w_drn;

    logic w_main_load;
    logic w_main_from_skid;
    logic w_main_clr_ctrl;
    logic w_main_clr_data;
    logic w_skid_load;

    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    // Handshake terms. With a skid entry, ready comes straight from a flop so
    // there is no path from downstream ready to upstream ready; without it,
    // the single entry can be refilled in the same cycle it drains.
    assign w_valid = is_occupied(r_state);
    assign w_ready = SKID_EN ? r_ready : (!w_valid || o_dn.ready);
    assign w_acc   = i_up.valid && w_ready;
    assign w_drn   = w_valid && o_dn.ready;

    // State register plus registered ready (high whenever the next state is not FULL).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Next-state logic; flush overrides every handshake outcome.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (w_acc && !w_drn) begin
                        w_state_nxt = SKID_EN ? ST_FULL : ST_MAIN;
                    end else if (!w_acc && w_drn) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        w_state_nxt = ST_MAIN;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Entry control: which entry loads, from where, and when main becomes a bubble.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr_ctrl  = 1'b0;
        w_main_clr_data  = 1'b0;
        w_skid_load      = 1'b0;
        if (i_flush) begin
            w_main_clr_ctrl = 1'b1;
            w_main_clr_data = CLR_DATA_EN;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    w_main_load = w_acc;
                end
                ST_MAIN: begin
                    if (w_acc && (w_drn || !SKID_EN)) begin
                        w_main_load = 1'b1;
                    end else if (w_acc) begin
                        w_skid_load = 1'b1;
                    end else if (w_drn) begin
                        w_main_clr_ctrl = 1'b1;
                        w_main_clr_data = CLR_DATA_EN;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_main_clr_ctrl = 1'b1;
                    w_main_clr_data = CLR_DATA_EN;
                end
            endcase
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : i_up.ctrl;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : i_up.data;

    pipe_stage_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_main_load),
        .i_clear_ctrl (w_main_clr_ctrl),
        .i_clear_data (w_main_clr_data),
        .i_ctrl       (w_main_ctrl_in),
        .i_data       (w_main_data_in),
        .o_ctrl       (w_main_ctrl),
        .o_data       (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            // Parking slot for the beat accepted while downstream stalls.
            pipe_stage_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .i_clk        (i_clk),
                .i_rst        (i_rst),
                .i_load       (w_skid_load),
                .i_clear_ctrl (i_flush),
                .i_clear_data (i_flush),
                .i_ctrl       (i_up.ctrl),
                .i_data       (i_up.data),
                .o_ctrl       (w_skid_ctrl),
                .o_data       (w_skid_data)
            );
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    // Stall counter: counts cycles a beat is offered but refused, sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !o_dn.ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign i_up.ready  = w_ready;
    assign o_dn.valid  = w_valid;
    assign o_dn.ctrl   = w_main_ctrl;
    assign o_dn.data   = w_main_data;
    assign o_stall_cnt = r_stall_cnt;
    assign o_dbg_state = r_state;

endmodule
